// File: rtl/gate_unit_arbiter.sv
// rtl/gate_unit_arbiter.sv - round-robin arbiter feeding a shared two-input logic gate unit
// One transaction at a time: grant captures operands, EXEC computes, RESP holds until accepted.
module gate_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     a_in,
  input  logic [N_REQ-1:0]     b_in,
  input  logic [3*N_REQ-1:0]   op_in,
  output logic [N_REQ-1:0]     gnt,
  output logic                 res_valid,
  output logic                 res_out,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_err,
  input  logic                 res_ready,
  output logic                 busy,
  output logic [7:0]           txn_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [ID_W:0] NQ = (ID_W+1)'(N_REQ);

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt, win_id;
  logic            win_found, grant_en;
  logic [ID_W:0]   sum, psum;
  logic            cap_a, cap_b;
  logic [2:0]      cap_op;
  logic [ID_W-1:0] cap_id;
  logic            gate_res, gate_err;

  // Search upward from ptr with wrap; first requesting index wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    sum       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= NQ) sum = sum - NQ;
      if (!win_found && req[sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    psum    = {1'b0, win_id} + (ID_W+1)'(1);
    ptr_nxt = (psum >= NQ) ? '0 : psum[ID_W-1:0];
  end

  assign grant_en = win_found && ((state == IDLE) || ((state == RESP) && res_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = win_found ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    gate_res = 1'b0;
    gate_err = 1'b0;
    case (cap_op)
      3'd0:    gate_res = cap_a & cap_b;
      3'd1:    gate_res = cap_a | cap_b;
      3'd2:    gate_res = ~(cap_a & cap_b);
      3'd3:    gate_res = ~(cap_a | cap_b);
      3'd4:    gate_res = cap_a ^ cap_b;
      3'd5:    gate_res = ~(cap_a ^ cap_b);
      default: gate_err = 1'b1;
    endcase
  end

  // Operands are only ever sampled on a grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      ptr    <= '0;
      cap_a  <= 1'b0;
      cap_b  <= 1'b0;
      cap_op <= 3'd0;
      cap_id <= '0;
    end else begin
      gnt <= '0;
      if (grant_en) begin
        gnt    <= N_REQ'(1) << win_id;
        ptr    <= ptr_nxt;
        cap_a  <= a_in[win_id];
        cap_b  <= b_in[win_id];
        cap_op <= op_in[win_id*3 +: 3];
        cap_id <= win_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_out   <= 1'b0;
      res_err   <= 1'b0;
      res_id    <= '0;
      txn_cnt   <= 8'd0;
    end else begin
      if (state == EXEC) begin
        res_valid <= 1'b1;
        res_out   <= gate_res;
        res_err   <= gate_err;
        res_id    <= cap_id;
      end else if ((state == RESP) && res_ready) begin
        res_valid <= 1'b0;
      end
      if (res_valid && res_ready) txn_cnt <= txn_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb/tb_gate_unit_arbiter.sv - self-checking bench for gate_unit_arbiter
// Reference model: truth-table lookup per opcode and a modular round-robin pointer.
module tb_gate_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, a_in, b_in, gnt;
  logic [11:0] op_in;
  logic        res_valid, res_out, res_err, res_ready, busy;
  logic [1:0]  res_id;
  logic [7:0]  txn_cnt;

  int vectors = 0;
  int miscompares = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  logic [3:0] tt [0:5];

  gate_unit_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .res_valid(res_valid), .res_out(res_out), .res_id(res_id),
    .res_err(res_err), .res_ready(res_ready), .busy(busy), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_winner(input logic [3:0] mask, input int p);
    for (int k = 0; k < 4; k++) if (mask[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic int op_of(input logic [11:0] op, input int id);
    return int'((op >> (3 * id)) & 12'd7);
  endfunction

  function automatic logic exp_out(input logic [3:0] a, input logic [3:0] b, input logic [11:0] op, input int id);
    int o;
    logic [3:0] row;
    o = op_of(op, id);
    if (o >= 6) return 1'b0;
    row = tt[o];
    return row[int'(a[id]) * 2 + int'(b[id])];
  endfunction

  task automatic do_reset();
    req = 4'd0; res_ready = 1'b0; rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    m_ptr = 0; m_cnt = 0;
  endtask

  // Drives one isolated transaction from IDLE and returns what the DUT showed.
  task automatic do_txn(input logic [3:0] mask, input int stall, output logic [3:0] g,
                        output logic [4:0] res, output logic [7:0] cnt, output logic rv_after);
    req = mask; res_ready = 1'b0;
    step();
    g = gnt; req = 4'd0;
    step();
    repeat (stall) step();
    res = {res_valid, res_out, res_err, res_id};
    res_ready = 1'b1;
    step();
    cnt = txn_cnt; rv_after = res_valid; res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'd0; a_in = 4'd0; b_in = 4'd0; op_in = 12'd0; res_ready = 1'b0;
    #2;
    vectors++;
    if ({gnt, res_valid, res_out, res_err, res_id, busy, txn_cnt} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want all zero", {gnt, res_valid, res_out, res_err, res_id, busy, txn_cnt});
    end
    step(); step();
    rst_n = 1'b1;
    step();
    vectors++;
    if ({gnt, busy, res_valid} !== 6'd0) begin
      miscompares++;
      $display("FAIL release_idle: got %b want 000000", {gnt, busy, res_valid});
    end
  endtask

  task automatic run_and_check(input string name, input logic [3:0] mask, input int stall);
    logic [3:0] g; logic [4:0] res; logic [7:0] cnt; logic rva;
    logic [3:0] sa, sb; logic [11:0] so; int w; logic [4:0] eres;
    sa = a_in; sb = b_in; so = op_in;
    w = exp_winner(mask, m_ptr);
    eres = {1'b1, exp_out(sa, sb, so, w), (op_of(so, w) >= 6), 2'(w)};
    do_txn(mask, stall, g, res, cnt, rva);
    m_ptr = (w + 1) % 4;
    m_cnt = (m_cnt + 1) % 256;
    vectors++;
    if (g !== 4'(1 << w)) begin
      miscompares++;
      $display("FAIL %s gnt: got %b want %b", name, g, 4'(1 << w));
    end
    vectors++;
    if (res !== eres) begin
      miscompares++;
      $display("FAIL %s result v/out/err/id: got %b want %b (op %0d)", name, res, eres, op_of(so, w));
    end
    vectors++;
    if ({cnt, rva} !== {8'(m_cnt), 1'b0}) begin
      miscompares++;
      $display("FAIL %s accept cnt/valid: got %0d/%b want %0d/0", name, cnt, rva, m_cnt);
    end
  endtask

  task automatic test_single();
    a_in = 4'b0010; b_in = 4'b0000; op_in = 12'd4 << 3;
    run_and_check("single", 4'b0010, 0);
    vectors++;
    if (txn_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL single_txn_cnt: got %0d want 1", txn_cnt);
    end
  endtask

  task automatic test_truth_table();
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
        a_in[2] = ab[1]; b_in[2] = ab[0]; op_in[8:6] = 3'(op);
        run_and_check("truth_table", 4'b0100, 0);
      end
    end
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
    res_ready = 1'b1; req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      w = exp_winner(4'hF, m_ptr);
      m_ptr = (w + 1) % 4;
      vectors++;
      if ({gnt, res_valid, txn_cnt} !== {4'(1 << w), 1'b0, 8'(m_cnt)}) begin
        miscompares++;
        $display("FAIL rr_grant_cycle %0d: gnt/valid/cnt got %b/%b/%0d want %b/0/%0d", k, gnt, res_valid, txn_cnt, 4'(1 << w), m_cnt);
      end
      step();
      vectors++;
      if ({res_valid, res_out, res_err, res_id, gnt} !== {1'b1, exp_out(a_in, b_in, op_in, w), (op_of(op_in, w) >= 6), 2'(w), 4'd0}) begin
        miscompares++;
        $display("FAIL rr_result %0d: got %b id %0d want requester %0d", k, {res_valid, res_out, res_err, res_id, gnt}, res_id, w);
      end
      m_cnt = (m_cnt + 1) % 256;
    end
    req = 4'd0;
    step();
    vectors++;
    if ({res_valid, busy, gnt, txn_cnt} !== {1'b0, 1'b0, 4'd0, 8'(m_cnt)}) begin
      miscompares++;
      $display("FAIL rr_drain: valid/busy/gnt/cnt got %b/%b/%b/%0d want 0/0/0000/%0d", res_valid, busy, gnt, txn_cnt, m_cnt);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] sa, sb; logic [11:0] so; int w; logic [4:0] eres;
    a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
    sa = a_in; sb = b_in; so = op_in;
    res_ready = 1'b0; req = 4'($urandom_range(1, 15));
    w = exp_winner(req, m_ptr);
    eres = {1'b1, exp_out(sa, sb, so, w), (op_of(so, w) >= 6), 2'(w)};
    step();
    m_ptr = (w + 1) % 4;
    vectors++;
    if (gnt !== 4'(1 << w)) begin
      miscompares++;
      $display("FAIL bp_gnt: got %b want %b", gnt, 4'(1 << w));
    end
    req = 4'($urandom); a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if ({res_valid, res_out, res_err, res_id, gnt, busy} !== {eres, 4'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: got %b want %b", k, {res_valid, res_out, res_err, res_id, gnt, busy}, {eres, 4'd0, 1'b1});
      end
      req = 4'($urandom); a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
    end
    req = 4'd0; res_ready = 1'b1;
    step();
    m_cnt = (m_cnt + 1) % 256;
    vectors++;
    if ({res_valid, gnt, busy, txn_cnt} !== {1'b0, 4'd0, 1'b0, 8'(m_cnt)}) begin
      miscompares++;
      $display("FAIL bp_accept: valid/gnt/busy/cnt got %b/%b/%b/%0d want 0/0000/0/%0d", res_valid, gnt, busy, txn_cnt, m_cnt);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
      run_and_check("random", 4'($urandom_range(1, 15)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
    req = 4'b0010; res_ready = 1'b0;
    step();
    req = 4'd0; rst_n = 1'b0;
    #1;
    m_ptr = 0; m_cnt = 0;
    vectors++;
    if ({gnt, res_valid, busy, txn_cnt} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async: gnt/valid/busy/cnt got %b/%b/%b/%0d want all zero", gnt, res_valid, busy, txn_cnt);
    end
    step();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_result: res_valid got %b want 0", res_valid);
    end
    rst_n = 1'b1;
    a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
    run_and_check("reset_mid_regrant", 4'b1001, 1);
  endtask

  task automatic test_wrap();
    int w;
    do_reset();
    a_in = 4'($urandom); b_in = 4'($urandom); op_in = 12'($urandom);
    res_ready = 1'b1; req = 4'hF;
    for (int k = 0; k < 256; k++) begin
      step();
      w = exp_winner(4'hF, m_ptr);
      m_ptr = (w + 1) % 4;
      vectors++;
      if ({gnt, txn_cnt} !== {4'(1 << w), 8'(m_cnt)}) begin
        miscompares++;
        $display("FAIL wrap_grant %0d: gnt/cnt got %b/%0d want %b/%0d", k, gnt, txn_cnt, 4'(1 << w), m_cnt);
      end
      step();
      m_cnt = (m_cnt + 1) % 256;
    end
    req = 4'd0;
    step();
    vectors++;
    if ({txn_cnt, res_valid} !== {8'(m_cnt), 1'b0} || m_cnt != 0) begin
      miscompares++;
      $display("FAIL wrap_final: cnt/valid got %0d/%b want 0/0", txn_cnt, res_valid);
    end
    res_ready = 1'b0;
  endtask

  initial begin
    tt[0] = 4'b1000;
    tt[1] = 4'b1110;
    tt[2] = 4'b0111;
    tt[3] = 4'b0001;
    tt[4] = 4'b0110;
    tt[5] = 4'b1001;
    test_reset();
    test_single();
    test_truth_table();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gate_unit_arbiter.md
GATE_UNIT_ARBITER -- requirements
Module: gate_unit_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the gate unit; legal values 2..8.
REQ-002 Parameter ID_W, default 2, width of requester index; SHALL equal clog2(N_REQ).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  per-requester request; held high until the matching gnt bit.
REQ-006 a_in  input  N_REQ  operand a, bit i belongs to requester i.
REQ-007 b_in  input  N_REQ  operand b, bit i belongs to requester i.
REQ-008 op_in  input  3*N_REQ  opcode, bits [3i+2:3i] belong to requester i.
REQ-009 gnt  output  N_REQ  one-hot acceptance pulse, one cycle, marks operand capture.
REQ-010 res_valid  output  1  result available; held until accepted.
REQ-011 res_out  output  1  gate result.
REQ-012 res_id  output  ID_W  index of requester owning res_out.
REQ-013 res_err  output  1  opcode was illegal (6 or 7); qualified by res_valid.
REQ-014 res_ready  input  1  consumer accepts result when high with res_valid.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 txn_cnt  output  8  count of completed transactions (res_valid & res_ready).

Function
REQ-017 Opcode map: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR of captured a,b.
REQ-018 Opcodes 6, 7: res_out SHALL be 0 and res_err 1; otherwise res_err 0.
REQ-019 States: IDLE, EXEC, RESP; encoding free; no other reachable state.
REQ-020 IDLE: if |req at the edge, go to EXEC, pulse gnt for the winner, and capture that winner's a, b, op and index; else stay IDLE, gnt all-zero.
REQ-021 Arbitration: round-robin; search starts at pointer ptr and proceeds upward with wrap from N_REQ-1 to 0; the first set req bit wins.
REQ-022 ptr resets to 0; on each grant ptr SHALL become (winner+1) mod N_REQ.
REQ-023 A requester whose req is low at the sampling edge is never granted; a single active requester is granted regardless of ptr.
REQ-024 EXEC lasts exactly one cycle: register res_out/res_err/res_id from captured values, assert res_valid, go to RESP.
REQ-025 Latency: gnt is high in the cycle after req is sampled; res_valid is high two cycles after req is sampled.
REQ-026 RESP: res_valid, res_out, res_id, res_err SHALL remain stable while res_ready is low, for any number of cycles.
REQ-027 RESP with res_ready high and no req: deassert res_valid, go to IDLE.
REQ-028 RESP with res_ready high and |req: arbitrate as in IDLE in the same edge, pulse gnt, go directly to EXEC (back-to-back; res_valid low for exactly one cycle).
REQ-029 req changes while in EXEC, or in RESP with res_ready low, SHALL have no effect; operands are never sampled outside a grant edge.
REQ-030 txn_cnt increments by 1 on each edge with res_valid & res_ready, wrapping 255 -> 0.
REQ-031 gnt SHALL never have more than one bit set; gnt SHALL be zero in every cycle not immediately following a grant edge.

Reset
REQ-032 While rst_n is low: state IDLE, gnt 0, res_valid 0, res_out 0, res_id 0, res_err 0, ptr 0, txn_cnt 0, busy 0, all applied asynchronously.
REQ-033 Reset asserted mid-transaction SHALL abort it with no result delivered; first grant after release follows ptr=0.
REQ-034 Release of rst_n SHALL take effect on the next rising edge; no grant on the release edge unless req is sampled then.

Verification
REQ-035 Single request: N_REQ=4, req=4'b0010, a1=1, b1=0, op1=4 (XOR), res_ready=1 -> gnt=4'b0010 at T+1, res_valid at T+2 with res_out=1, res_id=1, res_err=0, txn_cnt=1.
REQ-036 Full truth table: one requester steps {a,b}=00,01,10,11 through op 0..5 -> res_out matches AND/OR/NAND/NOR/XOR/XNOR for all 24 cases; op 6 and 7 -> res_out=0, res_err=1.
REQ-037 Round-robin fairness: req=4'b1111 held, res_ready=1 -> grant order 0,1,2,3,0 with back-to-back transactions and res_valid low exactly one cycle between results.
REQ-038 Backpressure: res_ready=0 for 5 cycles in RESP while req changes -> res_* stable, no gnt; res_ready=1 -> single accept, txn_cnt +1.
REQ-039 Reset mid-op: rst_n low during EXEC -> res_valid=0, gnt=0, txn_cnt=0 immediately; after release req=4'b1001 -> requester 0 granted first.
REQ-040 Counter wrap: 256 completed transactions -> txn_cnt returns to 0.
